// File: rtl/mul_pkg.sv
// Shared definitions for the sequential multiplier family: FSM state
// encoding and the iteration-counter width helper.
package mul_pkg;

  typedef logic [0:0] state_t;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Counter must be able to hold the value WIDTH itself.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/mul_sign_mag.sv
// Conditional two's-complement negate, used both to take operand magnitudes
// and to re-apply the sign to the unsigned product.
module mul_sign_mag #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] x,
  input  logic             neg,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = x;
    if (neg) begin
      y = (~x) + WIDTH'(1);
    end
  end

endmodule

// File: rtl/mul_seq_param.sv
// Sequential shift-add multiplier: one multiplier bit per cycle, WIDTH cycles
// per product, signed operation by sign/magnitude conversion around the core.
//
// Handshake: start is sampled only on an edge where busy=0; a start seen while
// busy=1 is dropped. done pulses for one cycle with y valid, and in that same
// cycle busy=0, so a start held through it is accepted on the next edge.
module mul_seq_param
  import mul_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   y,
  output logic [0:0]           dbg_state
);

  localparam int              CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  state_t              state;
  logic [WIDTH-1:0]    mcand;
  logic [2*WIDTH:0]    acc;
  logic [2*WIDTH:0]    acc_next;
  logic [CW-1:0]       cnt;
  logic                neg;

  logic                neg_a;
  logic                neg_b;
  logic [WIDTH-1:0]    a_mag;
  logic [WIDTH-1:0]    b_mag;
  logic [WIDTH:0]      upper_sum;
  logic [2*WIDTH-1:0]  prod_final;
  logic                last_step;

  assign neg_a = is_signed & a[WIDTH-1];
  assign neg_b = is_signed & b[WIDTH-1];

  mul_sign_mag #(.WIDTH(WIDTH)) u_mag_a (
    .x   (a),
    .neg (neg_a),
    .y   (a_mag)
  );

  mul_sign_mag #(.WIDTH(WIDTH)) u_mag_b (
    .x   (b),
    .neg (neg_b),
    .y   (b_mag)
  );

  // The multiplier magnitude sits in the low half of acc and is consumed from
  // bit 0 as product bits shift in from above.
  always_comb begin
    upper_sum = acc[2*WIDTH:WIDTH];
    if (acc[0]) begin
      upper_sum = upper_sum + {1'b0, mcand};
    end
    acc_next = {1'b0, upper_sum, acc[WIDTH-1:1]};
  end

  assign last_step = (cnt == LAST);

  // Sign is applied to the post-step value so y is ready at the completing edge.
  mul_sign_mag #(.WIDTH(2*WIDTH)) u_res (
    .x   (acc_next[2*WIDTH-1:0]),
    .neg (neg),
    .y   (prod_final)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      mcand <= '0;
      acc   <= '0;
      cnt   <= '0;
      neg   <= 1'b0;
      done  <= 1'b0;
      y     <= '0;
    end else begin
      done <= 1'b0;
      if (state == ST_IDLE) begin
        if (start) begin
          mcand <= a_mag;
          acc   <= {{(WIDTH+1){1'b0}}, b_mag};
          cnt   <= '0;
          neg   <= neg_a ^ neg_b;
          state <= ST_RUN;
        end
      end else begin
        acc <= acc_next;
        cnt <= cnt + CW'(1);
        if (last_step) begin
          y     <= prod_final;
          done  <= 1'b1;
          state <= ST_IDLE;
        end
      end
    end
  end

  assign busy      = (state == ST_RUN);
  assign dbg_state = state;

endmodule

// File: doc/mul_seq_param.md
# mul_seq_param

Parametrised sequential shift-add multiplier. It is the successor to the team's fixed 8-bit combinational unsigned multiplier. It takes two WIDTH-bit operands, treats them as unsigned or two's-complement per request, and produces the 2·WIDTH-bit product after WIDTH clock cycles. It trades area for latency in datapaths that cannot afford a full array multiplier, and accepts one request at a time via a start/busy/done handshake.

## Interface
- WIDTH, default 8: operand width in bits (≥2); product width is 2·WIDTH.
- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  request strobe; sampled only while idle.
- is_signed  in  1  1 = operands are two's-complement, 0 = unsigned; sampled with start.
- a  in  WIDTH  multiplicand; sampled with start.
- b  in  WIDTH  multiplier; sampled with start.
- busy  out  1  high while a multiplication is in progress.
- done  out  1  one-cycle pulse when y holds a new result.
- y  out  2·WIDTH  product; holds last result until the next completion.

## Operation
- States: IDLE, RUN.
- IDLE, start=1 at an edge:
  - latch |a|, |b| as WIDTH-bit magnitudes (abs only when is_signed=1 and MSB set);
  - latch neg = is_signed & (a[MSB] ^ b[MSB]);
  - clear accumulator and counter; go to RUN; busy=1.
- IDLE, start=0: no change.
- RUN, each edge:
  - if the current multiplier LSB is 1, add the multiplicand to the upper accumulator half;
  - shift the {carry, accumulator} pair right by 1; increment the counter.
- RUN, on the edge where the counter reaches WIDTH (the WIDTH-th RUN edge):
  - y ← neg ? −acc : acc (2·WIDTH-bit two's complement);
  - done=1 for one cycle; busy=0; go to IDLE.
- Width rules:
  - magnitude of the most negative value (e.g. −128) fits in the WIDTH-bit unsigned magnitude;
  - the product always fits in 2·WIDTH bits, no overflow in either mode;
  - accumulator is 2·WIDTH+1 bits including the add carry.
- start while busy=1: ignored; the operation in progress is unaffected; no queuing.
- start in the same cycle as done=1: accepted (state is IDLE); back-to-back throughput is one result per WIDTH cycles.
- Operand or is_signed changes after the accepting edge have no effect.
- Zero operands still take the full WIDTH cycles (no early termination).

## Timing
- Reset values: busy=0, done=0, y=0, state IDLE, counter 0.
- Reset asserted mid-operation aborts immediately; no done pulse. y returns to 0.
- Latency: start sampled at edge k → done=1 and y valid in the cycle after edge k+WIDTH.
- busy=1 in the cycles after edges k … k+WIDTH−1; busy=0 in the same cycle done=1.
- y changes only at a completing edge or at reset. All outputs are registered; there are no combinational input-to-output paths.
- Counter width is $clog2(WIDTH+1).

## Structure
- Shared package (mul_pkg): state encoding localparams (IDLE, RUN) and the counter-width function. These are reused by future multi-bit/Booth variants.
- One sub-module: mul_sign_mag, purely combinational, parametrised by WIDTH.
  - Provides conditional two's-complement negate.
  - Instantiated once for operand magnitude (×2 at width WIDTH) and once for the result (width 2·WIDTH).
- Top level holds the FSM, counter, accumulator and output registers.

## Test plan
All scenarios use WIDTH=8.
- Unsigned corners, is_signed=0:
  - 0×255 → y=0x0000;
  - 255×255 → y=0xFE01;
  - done exactly 8 cycles after the start edge; busy high the 8 cycles before.
- Signed, is_signed=1:
  - a=0xFF, b=0xFF (−1×−1) → 0x0001;
  - a=0x07, b=0xF7 (7×−9) → 0xFFC1;
  - a=0x80, b=0x80 (−128×−128) → 0x4000;
  - a=0x80, b=0x7F (−128×127) → 0xC080.
- Mode switch with the same bits: a=0xFF, b=0x02 gives 0x01FE when is_signed=0 and 0xFFFE when is_signed=1.
- start pulsed with new operands 3 cycles into an operation:
  - ignored; the first result is unaffected;
  - exactly one done pulse.
- Back-to-back: start held high continuously with 23×19 then 200×100:
  - done pulses 8 cycles apart;
  - y=0x01B5, then y=0x4E20.
- rst asserted mid-RUN (cycle 4):
  - busy, done and y go to 0 immediately;
  - no done pulse afterwards;
  - the next start (7×9) yields 0x003F normally.
